// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the convolution core and its downstream stages.
package conv_pkg;

  localparam int DEF_DATA_WIDTH = 16;

  typedef logic signed [DEF_DATA_WIDTH-1:0] data_t;

  function automatic int calc_in_w(input int n, input int k);
    return n - k + 1;
  endfunction

  function automatic int calc_out_w(input int n, input int k);
    return (n - k + 1) / 2;
  endfunction

  // Counters carry one spare bit so IN_W itself is representable.
  function automatic int calc_cnt_w(input int in_w);
    return $clog2(in_w) + 1;
  endfunction

endpackage

// File: rtl/maxpool2x2_stage_if.sv
// Sample stream in (data/valid) and pooled stream out (data/valid/done) of the 2x2 max-pool stage.
interface maxpool2x2_stage_if #(
  parameter int DATA_WIDTH = conv_pkg::DEF_DATA_WIDTH
);
  logic signed [DATA_WIDTH-1:0] data_i;
  logic                         valid_i;
  logic signed [DATA_WIDTH-1:0] data_o;
  logic                         valid_o;
  logic                         done_o;

  modport master (output data_i, valid_i, input data_o, valid_o, done_o);
  modport slave  (input data_i, valid_i, output data_o, valid_o, done_o);
endinterface

// File: rtl/signed_max2.sv
// Combinational two-input signed maximum; ties return the shared value.
module signed_max2 #(
  parameter int DATA_WIDTH = 16
) (
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [DATA_WIDTH-1:0] y
);
  assign y = (a >= b) ? a : b;
endmodule

// File: rtl/maxpool2x2_stage.sv
// 2x2 stride-2 signed max pool over the raster-order convolution result stream.
// Optional build macro POOL_RELU_EN clamps negative samples to zero before pooling.
module maxpool2x2_stage
  import conv_pkg::*;
#(
  parameter int N          = 4,
  parameter int K_SIZE     = 3,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH
) (
  input logic          clk,
  input logic          rst,
  maxpool2x2_stage_if.slave bus
);
  localparam int IN_W     = calc_in_w(N, K_SIZE);
  localparam int OUT_W    = calc_out_w(N, K_SIZE);
  localparam int CW       = calc_cnt_w(IN_W);
  localparam int LB_DEPTH = (OUT_W > 0) ? OUT_W : 1;
  localparam int LB_AW    = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;

  typedef logic signed [DATA_WIDTH-1:0] smp_t;

  logic [CW-1:0]    col, row;
  logic [LB_AW-1:0] lb_idx;
  logic             accept, lb_wr, win_done;
  logic             valid_q, done_q;
  smp_t             sample, pair, hmax, vmax, lb_rd, data_q;
  smp_t             linebuf [LB_DEPTH];

  assign accept   = bus.valid_i & ~done_q;
  assign lb_idx   = LB_AW'(col >> 1);
  assign lb_wr    = accept & col[0] & ~row[0];
  assign win_done = accept & col[0] & row[0];

  always_comb begin
`ifdef POOL_RELU_EN
    sample = bus.data_i[DATA_WIDTH-1] ? '0 : bus.data_i;
`else
    sample = bus.data_i;
`endif
  end

  signed_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_hmax (.a(pair),  .b(sample), .y(hmax));
  signed_max2 #(.DATA_WIDTH(DATA_WIDTH)) u_vmax (.a(lb_rd), .b(hmax),   .y(vmax));

  // Entries are always written on the even row before the odd row reads them, so no reset.
  always_ff @(posedge clk) begin
    for (int e = 0; e < LB_DEPTH; e++)
      if (lb_wr && lb_idx == LB_AW'(e)) linebuf[e] <= hmax;
  end

  always_comb begin
    lb_rd = '0;
    for (int e = 0; e < LB_DEPTH; e++)
      if (lb_idx == LB_AW'(e)) lb_rd = linebuf[e];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col     <= '0;
      row     <= '0;
      pair    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (accept) begin
        if (!col[0]) pair <= sample;
        if (win_done) begin
          data_q  <= vmax;
          valid_q <= 1'b1;
        end
        if (col == CW'(IN_W - 1)) begin
          col <= '0;
          if (row == CW'(IN_W - 1)) begin
            row    <= '0;
            done_q <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.done_o  = done_q;

endmodule
